alu_cmd_issuer: RTL and testbench

Command-side initiator for the registered ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand, select and enable ports. It captures the registered result and status one cycle after issue and buffers completed results in a small FIFO with its own valid/ready output. It sits between the datapath controller and the ALU instance, so upstream logic never has to track ALU pipeline timing.

---
 rtl/alu_cmd_issuer.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for the registered ALU: issues one command at a time and buffers results in a FIFO.
// Optional build macro ALU_DIV0_TRAP_EN traps divide-by-zero locally instead of issuing it to the ALU.
module alu_cmd_issuer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [2:0]         cmd_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_select,
    output logic               alu_enable,
    input  logic [2*WIDTH-1:0] alu_out,
    input  logic               alu_carry,
    input  logic               alu_inf,
    input  logic               alu_gt,
    input  logic               alu_eq,
    input  logic               alu_lt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic [2:0]         res_op,
    output logic               res_carry,
    output logic               res_inf,
    output logic               res_err,
    output logic               res_gt,
    output logic               res_eq,
    output logic               res_lt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [2*WIDTH-1:0] data;
        logic [2:0]         op;
        logic               carry;
        logic               inf;
        logic               err;
        logic               gt;
        logic               eq;
        logic               lt;
    } entry_t;

    state_t        state_q, state_d;
    logic          run_q;
    logic          accept, push, pop;
    logic          trap_cmd, trap_q, hold_q;
    entry_t        push_entry, head;
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // run_q keeps cmd_ready low while reset is held and until the first edge after release
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) run_q <= 1'b0;
        else         run_q <= 1'b1;
    end

`ifdef ALU_DIV0_TRAP_EN
    assign trap_cmd = (cmd_op == 3'b111) && (cmd_b == '0);

    // A trapped command skips ISSUE but spends two cycles in WAIT, so its push lands on the same edge
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            trap_q <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            hold_q <= accept && trap_cmd;
            if (accept) trap_q <= trap_cmd;
        end
    end
`else
    assign trap_cmd = 1'b0;
    assign trap_q   = 1'b0;
    assign hold_q   = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = run_q && (count_q < FULL);
                accept    = cmd_valid && cmd_ready;
                if (accept) state_d = trap_cmd ? WAIT : ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!hold_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            alu_enable <= 1'b0;
        end else begin
            alu_enable <= accept && !trap_cmd;
            if (accept) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_select <= cmd_op;
            end
        end
    end

    always_comb begin
        push_entry.data  = trap_q ? '0 : alu_out;
        push_entry.op    = alu_select;
        push_entry.carry = alu_carry && !trap_q;
        push_entry.inf   = alu_inf || trap_q;
        push_entry.err   = trap_q;
        push_entry.gt    = alu_gt;
        push_entry.eq    = alu_eq;
        push_entry.lt    = alu_lt;
    end

    assign pop = res_ready && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Outputs are masked when empty so stale storage never shows (and reset reads as zero)
    assign res_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign res_data  = res_valid ? head.data  : '0;
    assign res_op    = res_valid ? head.op    : '0;
    assign res_carry = res_valid && head.carry;
    assign res_inf   = res_valid && head.inf;
    assign res_err   = res_valid && head.err;
    assign res_gt    = res_valid && head.gt;
    assign res_eq    = res_valid && head.eq;
    assign res_lt    = res_valid && head.lt;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU stub, directed vector table, hand sequences and a randomized scoreboard run.
module tb_alu_cmd_issuer;

`ifdef ALU_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk, arst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_select;
    logic       alu_enable;
    logic [7:0] alu_out;
    logic       alu_carry, alu_inf, alu_gt, alu_eq, alu_lt;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       res_carry, res_inf, res_err, res_gt, res_eq, res_lt;

    int n_cmp = 0;
    int n_err = 0;

    alu_cmd_issuer #(.WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_inf(alu_inf),
        .alu_gt(alu_gt), .alu_eq(alu_eq), .alu_lt(alu_lt),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op),
        .res_carry(res_carry), .res_inf(res_inf), .res_err(res_err),
        .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU stand-in
    logic [8:0] alu_t;
    logic [7:0] alu_nout;
    logic       alu_nc, alu_ninf;
    always_comb begin
        alu_t    = '0;
        alu_nout = '0;
        alu_nc   = 1'b0;
        alu_ninf = 1'b0;
        case (alu_select)
            3'd0: begin alu_t = {5'b0, alu_a} + {5'b0, alu_b}; alu_nout = {4'b0, alu_t[3:0]}; alu_nc = alu_t[4]; end
            3'd1: begin alu_t = {5'b0, alu_a} - {5'b0, alu_b}; alu_nout = {4'b0, alu_t[3:0]}; alu_nc = alu_t[8]; end
            3'd2: alu_nout = {4'b0, alu_a & alu_b};
            3'd3: alu_nout = {4'b0, alu_a | alu_b};
            3'd4: alu_nout = {4'b0, alu_a ^ alu_b};
            3'd5: alu_nout = {7'b0, alu_a == alu_b};
            3'd6: alu_nout = {4'b0, alu_a} * {4'b0, alu_b};
            default: begin
                if (alu_b == 4'd0) alu_ninf = 1'b1;
                else               alu_nout = {4'b0, alu_a / alu_b};
            end
        endcase
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            alu_out <= '0; alu_carry <= 1'b0; alu_inf <= 1'b0;
        end else if (alu_enable) begin
            alu_out <= alu_nout; alu_carry <= alu_nc; alu_inf <= alu_ninf;
        end
    end
    assign alu_gt = alu_a > alu_b;
    assign alu_eq = alu_a == alu_b;
    assign alu_lt = alu_a < alu_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] dut_pack();
        return {res_data, res_op, res_carry, res_inf, res_err, res_gt, res_eq, res_lt};
    endfunction

    // Reference result entry from the operation definitions
    function automatic logic [16:0] model(input int a, input int b, input int op);
        int d;
        bit c, inf, err;
        d = 0; c = 0; inf = 0; err = 0;
        case (op)
            0: begin d = (a + b) % 16; c = (a + b) > 15; end
            1: begin d = (a - b + 16) % 16; c = a < b; end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = (a == b) ? 1 : 0;
            6: d = a * b;
            default: begin
                if (b == 0) begin inf = 1; err = TRAP; end
                else d = a / b;
            end
        endcase
        return {8'(d), 3'(op), c, inf, err, a > b, a == b, a < b};
    endfunction

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, output bit ok);
        ok = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [16:0] exp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({nm, "_valid"}, 32'(seen), 32'd1);
        chk(nm, 32'(dut_pack()), 32'(exp));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [2:0] op;
        logic [7:0] data;
        logic       carry, inf, err, gt, eq, lt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [16:0] exp;
        logic [16:0] e [5];
        logic [16:0] done_q [$];
        logic [16:0] inflight;
        int stage;
        bit exp_rdy, acc, pp;

        vecs[0] = '{4'd9,  4'd8,  3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'd15, 4'd15, 3'd6, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{4'd3,  4'd5,  3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{4'd7,  4'd0,  3'd7, 8'h00, 1'b0, 1'b1, TRAP, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'd2,  4'd5,  3'd1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'd12, 4'd10, 3'd2, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'd12, 4'd10, 3'd3, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{4'd12, 4'd10, 3'd4, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{4'd13, 4'd4,  3'd7, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        arst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_alu_enable", 32'(alu_enable), 0);
        chk("rst_alu_ops", 32'({alu_a, alu_b, alu_select}), 0);
        chk("rst_res", 32'({res_valid, dut_pack()}), 0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 1);

        // Directed vectors with latency/enable checks
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, ok);
            chk("vec_accept", 32'(ok), 1);
            chk("vec_en_e0", 32'(alu_enable), 32'(!(TRAP && vecs[i].op == 3'd7 && vecs[i].b == 4'd0)));
            chk("vec_ops_e0", 32'({alu_a, alu_b, alu_select}), 32'({vecs[i].a, vecs[i].b, vecs[i].op}));
            chk("vec_busy_e0", 32'({cmd_ready, res_valid}), 0);
            @(negedge clk);
            chk("vec_en_e1", 32'(alu_enable), 0);
            chk("vec_hold_e1", 32'({alu_a, alu_b, alu_select}), 32'({vecs[i].a, vecs[i].b, vecs[i].op}));
            chk("vec_busy_e1", 32'({cmd_ready, res_valid}), 0);
            @(negedge clk);
            chk("vec_done_e2", 32'({cmd_ready, res_valid}), 32'b11);
            exp = {vecs[i].data, vecs[i].op, vecs[i].carry, vecs[i].inf, vecs[i].err,
                   vecs[i].gt, vecs[i].eq, vecs[i].lt};
            chk("vec_result", 32'(dut_pack()), 32'(exp));
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("vec_popped", 32'(res_valid), 0);
        end

        // Fill the FIFO: the fifth command must stall until one pop
        for (int i = 0; i < 5; i++) e[i] = model(i + 1, 3, 0);
        for (int i = 0; i < 4; i++) begin
            issue(4'(i + 1), 4'd3, 3'd0, ok);
            chk("fill_accept", 32'(ok), 1);
        end
        issue(4'd5, 4'd3, 3'd0, ok);
        chk("full_blocked", 32'(ok), 0);
        chk("full_ready_low", 32'(cmd_ready), 0);
        pop_expect("full_pop0", e[0]);
        issue(4'd5, 4'd3, 3'd0, ok);
        chk("full_fifth_accept", 32'(ok), 1);
        repeat (2) @(negedge clk);
        for (int i = 1; i < 5; i++) pop_expect("full_order", e[i]);
        chk("full_empty", 32'(res_valid), 0);

        // Push and pop on the same edge with two entries buffered
        issue(4'd6, 4'd2, 3'd1, ok); repeat (2) @(negedge clk);
        issue(4'd7, 4'd2, 3'd6, ok); repeat (2) @(negedge clk);
        issue(4'd9, 4'd9, 3'd5, ok);
        @(negedge clk);
        chk("pp_head_a", 32'(dut_pack()), 32'(model(6, 2, 1)));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("pp_ready", 32'(cmd_ready), 1);
        pop_expect("pp_b", model(7, 2, 6));
        pop_expect("pp_c", model(9, 9, 5));
        chk("pp_empty", 32'(res_valid), 0);

        // Reset during WAIT with one result buffered
        issue(4'd1, 4'd1, 3'd0, ok); repeat (2) @(negedge clk);
        issue(4'd4, 4'd4, 3'd0, ok);
        @(negedge clk);
        arst_n = 1'b0;
        #2;
        chk("rstw_outputs", 32'({res_valid, alu_enable, cmd_ready}), 0);
        chk("rstw_res", 32'(dut_pack()), 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        issue(4'd2, 4'd3, 3'd0, ok);
        chk("rstw_accept", 32'(ok), 1);
        repeat (2) @(negedge clk);
        pop_expect("rstw_result", {8'h05, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rstw_lost", 32'(res_valid), 0);

        // Randomized run against a cycle-counting scoreboard
        stage = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp_rdy = (stage == 0) && (done_q.size() < DEPTH);
            chk("rnd_ready", 32'(cmd_ready), 32'(exp_rdy));
            chk("rnd_valid", 32'(res_valid), 32'(done_q.size() > 0));
            if (done_q.size() > 0) chk("rnd_head", 32'(dut_pack()), 32'(done_q[0]));
            cmd_valid = (cyc < 700) && ($urandom_range(0, 3) != 0);
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = 4'($urandom_range(0, 15));
            cmd_op    = 3'($urandom_range(0, 7));
            res_ready = (cyc >= 700) || ($urandom_range(0, 2) == 0);
            acc = cmd_valid && exp_rdy;
            pp  = res_ready && (done_q.size() > 0);
            @(posedge clk);
            if (pp) void'(done_q.pop_front());
            if (stage == 2) begin
                done_q.push_back(inflight);
                stage = 0;
            end else if (stage == 1) begin
                stage = 2;
            end else if (acc) begin
                inflight = model(cmd_a, cmd_b, cmd_op);
                stage = 1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        chk("rnd_drained", 32'(done_q.size()), 0);
        chk("rnd_final_valid", 32'(res_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
